// File: rtl/ballot_controller.sv
// Polling-station ballot controller: sequences officer authorization, one
// candidate choice per voter, vote strobes to the tally block and session close.
module ballot_controller #(
    parameter int TIMEOUT    = 32,
    parameter int MAX_VOTERS = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       open_poll,
    input  logic       close_poll,
    input  logic       voter_auth,
    input  logic       btn_A,
    input  logic       btn_B,
    input  logic       btn_C,
    output logic       vote_A,
    output logic       vote_B,
    output logic       vote_C,
    output logic       ready_led,
    output logic       poll_open,
    output logic       poll_done,
    output logic       err_multi,
    output logic       err_timeout,
    output logic [7:0] ballots_cast
);

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_IDLE,
        ST_ARMED,
        ST_COMMIT,
        ST_RELEASE,
        ST_FINAL
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] MAX_COUNT  = 8'(MAX_VOTERS);

    state_t      state_reg, state_next;
    logic        pending_reg, pending_next;
    logic [7:0]  timer_reg, timer_next;
    logic [7:0]  ballots_reg, ballots_next;
    logic [2:0]  sel_reg, sel_next;
    logic        auth_prev_reg;
    logic [2:0]  vote_reg, vote_next;
    logic        ready_reg, open_reg, done_reg;
    logic        err_multi_reg, err_multi_next;
    logic        err_timeout_reg, err_timeout_next;

    logic [2:0]  buttons;
    logic        any_button;
    logic        single_button;
    logic        auth_rise;

    assign buttons       = {btn_A, btn_B, btn_C};
    assign any_button    = |buttons;
    assign single_button = $onehot(buttons);
    assign auth_rise     = voter_auth & ~auth_prev_reg;

    always_comb begin
        state_next       = state_reg;
        pending_next     = pending_reg;
        timer_next       = timer_reg;
        ballots_next     = ballots_reg;
        sel_next         = sel_reg;
        err_multi_next   = 1'b0;
        err_timeout_next = 1'b0;

        case (state_reg)
            ST_CLOSED: begin
                pending_next = 1'b0;
                if (open_poll) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (close_poll) begin
                    state_next = ST_FINAL;
                end else if (auth_rise && !any_button) begin
                    state_next = ST_ARMED;
                    timer_next = 8'd0;
                end
            end
            ST_ARMED: begin
                if (close_poll) begin
                    pending_next = 1'b1;
                end
                // A valid press beats a timeout expiring in the same cycle
                if (single_button) begin
                    state_next   = ST_COMMIT;
                    sel_next     = buttons;
                    ballots_next = ballots_reg + 8'd1;
                end else if (timer_reg == TIMER_LAST) begin
                    err_timeout_next = 1'b1;
                    state_next = (pending_reg || close_poll) ? ST_FINAL : ST_IDLE;
                end else begin
                    timer_next     = timer_reg + 8'd1;
                    err_multi_next = any_button;
                end
            end
            ST_COMMIT: begin
                if (close_poll) begin
                    pending_next = 1'b1;
                end
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (pending_reg || close_poll || ballots_reg == MAX_COUNT) begin
                    state_next = ST_FINAL;
                end else if (!any_button) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FINAL: begin
                state_next = ST_FINAL;
            end
            default: begin
                state_next = ST_CLOSED;
            end
        endcase

        vote_next = (state_next == ST_COMMIT) ? sel_next : 3'b000;
    end

    // Outputs are registered from the next-state decode so they track the state register exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_CLOSED;
            pending_reg     <= 1'b0;
            timer_reg       <= 8'd0;
            ballots_reg     <= 8'd0;
            sel_reg         <= 3'b000;
            auth_prev_reg   <= 1'b0;
            vote_reg        <= 3'b000;
            ready_reg       <= 1'b0;
            open_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_multi_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pending_reg     <= pending_next;
            timer_reg       <= timer_next;
            ballots_reg     <= ballots_next;
            sel_reg         <= sel_next;
            auth_prev_reg   <= voter_auth;
            vote_reg        <= vote_next;
            ready_reg       <= (state_next == ST_ARMED);
            open_reg        <= (state_next == ST_IDLE)   || (state_next == ST_ARMED) ||
                               (state_next == ST_COMMIT) || (state_next == ST_RELEASE);
            done_reg        <= (state_next == ST_FINAL);
            err_multi_reg   <= err_multi_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

    assign vote_A       = vote_reg[2];
    assign vote_B       = vote_reg[1];
    assign vote_C       = vote_reg[0];
    assign ready_led    = ready_reg;
    assign poll_open    = open_reg;
    assign poll_done    = done_reg;
    assign err_multi    = err_multi_reg;
    assign err_timeout  = err_timeout_reg;
    assign ballots_cast = ballots_reg;

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller: expected votes are queued when a valid
// press is driven and popped whenever a vote strobe is observed.
module tb_ballot_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       open_poll = 1'b0;
    logic       close_poll = 1'b0;
    logic       voter_auth = 1'b0;
    logic       btn_A = 1'b0;
    logic       btn_B = 1'b0;
    logic       btn_C = 1'b0;
    logic       vote_A, vote_B, vote_C;
    logic       ready_led, poll_open, poll_done;
    logic       err_multi, err_timeout;
    logic [7:0] ballots_cast;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];

    localparam logic [2:0] V_A = 3'b100;
    localparam logic [2:0] V_B = 3'b010;
    localparam logic [2:0] V_C = 3'b001;

    ballot_controller #(.TIMEOUT(4), .MAX_VOTERS(2)) dut (
        .clk(clk), .reset(reset),
        .open_poll(open_poll), .close_poll(close_poll), .voter_auth(voter_auth),
        .btn_A(btn_A), .btn_B(btn_B), .btn_C(btn_C),
        .vote_A(vote_A), .vote_B(vote_B), .vote_C(vote_C),
        .ready_led(ready_led), .poll_open(poll_open), .poll_done(poll_done),
        .err_multi(err_multi), .err_timeout(err_timeout),
        .ballots_cast(ballots_cast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock; sample 1 time unit after the edge and score any vote strobe.
    task automatic tick();
        logic [2:0] obs;
        logic [2:0] exp;
        @(posedge clk);
        #1;
        obs = {vote_A, vote_B, vote_C};
        if (obs != 3'b000) begin
            if (exp_q.size() != 0) exp = exp_q.pop_front();
            else exp = 3'b000;
            check("vote_strobe", 32'(obs), 32'(exp));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        open_poll = 1'b0; close_poll = 1'b0; voter_auth = 1'b0;
        btn_A = 1'b0; btn_B = 1'b0; btn_C = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic open_session();
        open_poll = 1'b1;
        tick();
        open_poll = 1'b0;
    endtask

    task automatic auth();
        voter_auth = 1'b1;
        tick();
        voter_auth = 1'b0;
    endtask

    initial begin
        // ---- Group 1: basic vote, timeout, multi-press, MAX_VOTERS ----
        do_reset();
        check("rst_open", 32'(poll_open), 32'd0);
        check("rst_done", 32'(poll_done), 32'd0);
        check("rst_ready", 32'(ready_led), 32'd0);
        check("rst_ballots", 32'(ballots_cast), 32'd0);
        auth();
        tick();
        check("closed_ignore", 32'(poll_open | ready_led), 32'd0);
        open_session();
        check("opened", 32'(poll_open), 32'd1);

        auth();
        check("armed_led", 32'(ready_led), 32'd1);
        btn_B = 1'b1; exp_q.push_back(V_B);
        tick();
        check("voteB_latency", 32'(vote_B), 32'd1);
        check("ballots_1", 32'(ballots_cast), 32'd1);
        btn_B = 1'b0;
        tick();
        check("voteB_1cycle", 32'(vote_B), 32'd0);
        tick();
        check("idle_after_rel", 32'({poll_open, ready_led}), 32'b10);

        auth();
        tick(); tick(); tick();
        check("armed_cycle4", 32'(ready_led), 32'd1);
        tick();
        check("err_timeout", 32'(err_timeout), 32'd1);
        check("timeout_idle", 32'({poll_open, ready_led}), 32'b10);
        tick();
        check("timeout_pulse", 32'(err_timeout), 32'd0);
        check("ballots_keep", 32'(ballots_cast), 32'd1);

        auth();
        btn_A = 1'b1; btn_C = 1'b1;
        tick();
        check("err_multi", 32'(err_multi), 32'd1);
        check("multi_armed", 32'(ready_led), 32'd1);
        tick(); tick();
        btn_A = 1'b0; exp_q.push_back(V_C);
        tick();
        check("voteC_at_tmo", 32'(vote_C), 32'd1);
        check("press_beats_tmo", 32'(err_timeout), 32'd0);
        check("ballots_2", 32'(ballots_cast), 32'd2);
        btn_C = 1'b0;
        tick();
        tick();
        check("max_final", 32'({poll_done, poll_open}), 32'b10);

        auth();
        btn_A = 1'b1;
        tick(); tick(); tick();
        btn_A = 1'b0;
        tick();
        check("final_ignore", 32'({ready_led, ballots_cast}), 32'h002);
        check("sb_empty_g1", 32'(exp_q.size()), 32'd0);

        // ---- Group 2: close while ARMED ----
        do_reset();
        open_session();
        auth();
        close_poll = 1'b1;
        tick();
        close_poll = 1'b0;
        check("close_armed", 32'(ready_led), 32'd1);
        btn_B = 1'b1; exp_q.push_back(V_B);
        tick();
        check("close_voteB", 32'(vote_B), 32'd1);
        btn_B = 1'b0;
        tick();
        tick();
        check("close_final", 32'({poll_done, poll_open}), 32'b10);
        auth();
        btn_C = 1'b1; open_poll = 1'b1;
        tick(); tick();
        btn_C = 1'b0; open_poll = 1'b0;
        tick();
        check("final_dead", 32'({poll_done, ready_led, ballots_cast}), 32'h201);
        check("sb_empty_g2", 32'(exp_q.size()), 32'd0);

        // ---- Group 3: held button with second auth, then reset mid-COMMIT ----
        do_reset();
        open_session();
        auth();
        btn_A = 1'b1; exp_q.push_back(V_A);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) voter_auth = 1'b1;
            if (i == 5) voter_auth = 1'b0;
            tick();
        end
        btn_A = 1'b0;
        tick();
        tick();
        check("held_once", 32'({poll_open, ready_led, ballots_cast}), 32'h201);

        auth();
        btn_C = 1'b1;
        @(posedge clk);
        #2;
        check("commit_pre", 32'(vote_C), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_commit_vote", 32'({vote_A, vote_B, vote_C}), 32'd0);
        check("rst_commit_outs", 32'({poll_open, poll_done, ready_led, err_multi, err_timeout, ballots_cast}), 32'd0);
        btn_C = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rst_closed", 32'(poll_open), 32'd0);
        check("sb_empty_g3", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
